// File: rtl/cordic_vector.sv
// Iterative vectoring-mode CORDIC: converts a Cartesian vector (x, y) into
// atan2(y, x) in Q3.29 radians and a gain-corrected Q2.30 magnitude.
module cordic_vector #(
    parameter int W    = 32,
    parameter int ITER = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] x_in,
    input  logic [W-1:0] y_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] angle,
    output logic [W-1:0] mag
);

    localparam int XW   = W + 2;
    localparam int IW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int PW   = XW + 32;
    localparam int SH_L = (W >= 32) ? W - 32 : 0;
    localparam int SH_R = (W < 32) ? 32 - W : 0;
    localparam logic [31:0] K_Q131 = 32'h4DBA76D4;

    // Angle constants are tabulated as 32-bit Q3.29 and rescaled to W bits.
    function automatic logic [W-1:0] scale_q(input logic [63:0] v);
        logic [63:0] r;
        r = v << SH_L;
        if (SH_R > 0)
            r = (v + ((64'd1 << SH_R) >> 1)) >> SH_R;
        return r[W-1:0];
    endfunction

    function automatic logic [63:0] atan32(input int i);
        case (i)
            0:       return 64'd421657428;
            1:       return 64'd248918915;
            2:       return 64'd131521918;
            3:       return 64'd66762579;
            4:       return 64'd33510843;
            5:       return 64'd16771758;
            6:       return 64'd8387925;
            7:       return 64'd4194219;
            8:       return 64'd2097141;
            9:       return 64'd1048575;
            default: return (i <= 29) ? (64'd1 << (29 - i)) : 64'd0;
        endcase
    endfunction

    localparam logic signed [W-1:0] HALF_PI = scale_q(64'h3243F6A9);
    localparam logic signed [W-1:0] PI_S    = scale_q(64'h6487ED51);

    typedef enum logic [1:0] {IDLE, PRE, ROT, SCALE} state_t;

    state_t               state_reg, state_next;
    logic signed [XW-1:0] x_reg, y_reg;
    logic signed [W-1:0]  z_reg;
    logic [IW-1:0]        iter_reg;
    logic                 zero_reg;
    logic                 done_reg;
    logic [W-1:0]         angle_reg, mag_reg;

    logic signed [W-1:0]  atan_rom [ITER];
    logic signed [XW-1:0] x_sh, y_sh;
    logic signed [W-1:0]  atan_i;
    logic [PW-1:0]        prod;
    logic [W-1:0]         angle_next;

    genvar gi;
    generate
        for (gi = 0; gi < ITER; gi++) begin : g_rom
            assign atan_rom[gi] = scale_q(atan32(gi));
        end
    endgenerate

    assign x_sh   = x_reg >>> iter_reg;
    assign y_sh   = y_reg >>> iter_reg;
    assign atan_i = atan_rom[iter_reg];
    assign prod   = PW'($unsigned(x_reg)) * PW'(K_Q131);

    // A zero vector has no defined angle, and -pi is folded onto +pi so the
    // result always lies in (-pi, +pi].
    always_comb begin
        angle_next = z_reg;
        if (zero_reg)
            angle_next = '0;
        else if (z_reg > PI_S || z_reg <= -PI_S)
            angle_next = PI_S;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = PRE;
            PRE:     state_next = ROT;
            ROT:     if (iter_reg == IW'(ITER - 1)) state_next = SCALE;
            SCALE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg     <= '0;
            y_reg     <= '0;
            z_reg     <= '0;
            iter_reg  <= '0;
            zero_reg  <= 1'b0;
            done_reg  <= 1'b0;
            angle_reg <= '0;
            mag_reg   <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        x_reg    <= {{2{x_in[W-1]}}, x_in};
                        y_reg    <= {{2{y_in[W-1]}}, y_in};
                        zero_reg <= (x_in == '0) && (y_in == '0);
                    end
                end
                PRE: begin
                    // Fold the left half-plane into the right so the
                    // rotations only need to cover +/- pi/2.
                    if (x_reg[XW-1] && !y_reg[XW-1]) begin
                        x_reg <= y_reg;
                        y_reg <= -x_reg;
                        z_reg <= HALF_PI;
                    end else if (x_reg[XW-1]) begin
                        x_reg <= -y_reg;
                        y_reg <= x_reg;
                        z_reg <= -HALF_PI;
                    end else begin
                        z_reg <= '0;
                    end
                    iter_reg <= '0;
                end
                ROT: begin
                    if (!y_reg[XW-1]) begin
                        x_reg <= x_reg + y_sh;
                        y_reg <= y_reg - x_sh;
                        z_reg <= z_reg + atan_i;
                    end else begin
                        x_reg <= x_reg - y_sh;
                        y_reg <= y_reg + x_sh;
                        z_reg <= z_reg - atan_i;
                    end
                    iter_reg <= iter_reg + 1'b1;
                end
                SCALE: begin
                    mag_reg   <= W'(prod >> 31);
                    angle_reg <= angle_next;
                    done_reg  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state_reg != IDLE);
    assign done  = done_reg;
    assign angle = angle_reg;
    assign mag   = mag_reg;

endmodule

// File: tb/tb_cordic_vector.sv
// Scoreboard bench for cordic_vector: requests push real-valued atan2/hypot
// expectations, an independent monitor checks each done pulse against them.
module tb_cordic_vector;

    localparam int  W     = 32;
    localparam int  ITER  = 16;
    localparam real TWO30 = 1073741824.0;
    localparam real TWO29 = 536870912.0;
    localparam real PI_R  = 3.14159265358979323846;
    localparam real TOL   = 1.0e-4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] x_in, y_in;
    logic         busy, done;
    logic [W-1:0] angle, mag;

    always #5 clk = ~clk;

    cordic_vector #(.W(W), .ITER(ITER)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x_in  (x_in),
        .y_in  (y_in),
        .busy  (busy),
        .done  (done),
        .angle (angle),
        .mag   (mag)
    );

    typedef struct {
        real   ang;
        real   mag;
        bit    is_zero;
        bit    want_pos;
        int    due;
        string tag;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input bit ok, input string detail);
        n_checks++;
        if (!ok) begin
            n_fails++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    function automatic exp_t model(input logic [31:0] xi, input logic [31:0] yi,
                                   input int due, input string tag);
        exp_t e;
        real  xr, yr;
        xr = $itor($signed(xi)) / TWO30;
        yr = $itor($signed(yi)) / TWO30;
        e.ang = $atan2(yr, xr);
        if (e.ang <= -PI_R) e.ang = PI_R;
        e.mag      = $sqrt(xr * xr + yr * yr);
        e.is_zero  = (xi == 32'd0) && (yi == 32'd0);
        e.want_pos = (yi == 32'd0) && ($signed(xi) < 0);
        e.due      = due;
        e.tag      = tag;
        return e;
    endfunction

    function automatic logic [31:0] to_q30(input real r);
        int v;
        v = $rtoi(r * TWO30 + ((r >= 0.0) ? 0.5 : -0.5));
        return 32'(v);
    endfunction

    exp_t mon_e;
    real  a_dut, m_dut, a_err, m_err;

    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                chk("spurious_done", 1'b0,
                    $sformatf("done seen at cycle %0d, required no done", cyc));
            end else begin
                mon_e = q.pop_front();
                chk({mon_e.tag, "_latency"}, cyc == mon_e.due,
                    $sformatf("done at cycle %0d, required %0d", cyc, mon_e.due));
                if (mon_e.is_zero) begin
                    chk({mon_e.tag, "_zero_angle"}, angle == '0,
                        $sformatf("angle %h, required 00000000", angle));
                    chk({mon_e.tag, "_zero_mag"}, mag == '0,
                        $sformatf("mag %h, required 00000000", mag));
                end else begin
                    a_dut = $signed(angle);
                    a_dut = a_dut / TWO29;
                    m_dut = mag;
                    m_dut = m_dut / TWO30;
                    a_err = a_dut - mon_e.ang;
                    if (a_err > PI_R) a_err = a_err - 2.0 * PI_R;
                    else if (a_err < -PI_R) a_err = a_err + 2.0 * PI_R;
                    m_err = (m_dut - mon_e.mag) / mon_e.mag;
                    chk({mon_e.tag, "_angle"}, a_err <= TOL && a_err >= -TOL,
                        $sformatf("angle %f rad (%h), required %f rad", a_dut, angle, mon_e.ang));
                    chk({mon_e.tag, "_mag"}, m_err <= TOL && m_err >= -TOL,
                        $sformatf("mag %f (%h), required %f", m_dut, mag, mon_e.mag));
                end
                if (mon_e.want_pos)
                    chk({mon_e.tag, "_pi_sign"}, $signed(angle) > 0,
                        $sformatf("angle %h, required positive +pi", angle));
            end
        end
    end

    // Called at a falling edge while the DUT is idle (or showing done).
    task automatic do_op(input logic [31:0] xi, input logic [31:0] yi,
                         input bit repulse, input string tag);
        int busy_cnt;
        bit got;
        q.push_back(model(xi, yi, cyc + 1 + ITER + 2, tag));
        x_in  = xi;
        y_in  = yi;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        busy_cnt = 0;
        got      = 1'b0;
        for (int k = 0; k < ITER + 10 && !got; k++) begin
            if (done) begin
                got = 1'b1;
            end else begin
                if (busy) busy_cnt++;
                x_in  = $urandom;
                y_in  = $urandom;
                start = (repulse && k == 5);
                @(negedge clk);
            end
        end
        start = 1'b0;
        chk({tag, "_busy"}, got && busy_cnt == ITER + 2 && !busy,
            $sformatf("done seen %0d, busy cycles %0d, busy at done %0d, required 1/%0d/0",
                      got, busy_cnt, busy, ITER + 2));
    endtask

    logic [31:0] dir_x [10] = '{32'h40000000, 32'h40000000, 32'hC0000000, 32'h00000000,
                                32'h00000000, 32'h00000000, 32'h80000000, 32'h80000000,
                                32'h7FFFFFFF, 32'hC0000000};
    logic [31:0] dir_y [10] = '{32'h00000000, 32'h40000000, 32'h00000000, 32'hC0000000,
                                32'h00000000, 32'h40000000, 32'h00000000, 32'h80000000,
                                32'h80000000, 32'hFFFFFFFF};

    initial begin
        logic [31:0] xi, yi;
        real         xr, yr, deg;

        rst   = 1'b1;
        start = 1'b0;
        x_in  = '0;
        y_in  = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy",  busy == 1'b0, $sformatf("busy %0d, required 0", busy));
        chk("reset_done",  done == 1'b0, $sformatf("done %0d, required 0", done));
        chk("reset_angle", angle == '0,  $sformatf("angle %h, required 00000000", angle));
        chk("reset_mag",   mag == '0,    $sformatf("mag %h, required 00000000", mag));
        rst = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 10; n++)
            do_op(dir_x[n], dir_y[n], 1'b0, $sformatf("dir%0d", n));

        for (int k = 0; k < 20; k++) begin
            deg = 13.0 + k * (346.0 / 19.0);
            xr  = $cos(deg * PI_R / 180.0);
            yr  = $sin(deg * PI_R / 180.0);
            do_op(to_q30(xr), to_q30(yr), k[0], $sformatf("sweep%0d", k));
        end

        // Abort during the eighth micro-rotation.
        repeat (2) @(negedge clk);
        x_in  = to_q30(0.6);
        y_in  = to_q30(0.3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy",  busy == 1'b0, $sformatf("busy %0d, required 0", busy));
        chk("abort_done",  done == 1'b0, $sformatf("done %0d, required 0", done));
        chk("abort_angle", angle == '0,  $sformatf("angle %h, required 00000000", angle));
        chk("abort_mag",   mag == '0,    $sformatf("mag %h, required 00000000", mag));
        @(negedge clk);
        rst = 1'b0;
        repeat (ITER + 4) @(negedge clk);
        do_op(to_q30(0.6), to_q30(0.3), 1'b0, "after_abort");

        for (int n = 0; n < 30; n++) begin
            do begin
                xi = $urandom;
                yi = $urandom;
                xr = $itor($signed(xi)) / TWO30;
                yr = $itor($signed(yi)) / TWO30;
            end while (xr * xr + yr * yr < 0.0625);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_op(xi, yi, (n % 4) == 0, $sformatf("rnd%0d", n));
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size() == 0,
            $sformatf("%0d results outstanding, required 0", q.size()));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, required bench completion");
        $fatal(1, "bench timed out");
    end

endmodule
